// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit with valid/ready on both sides.
//   S1 captures op/operands; S2 computes and registers result plus zero/parity flags.
// Parameters: WIDTH  operand/result width (1..64).
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       input handshake (in_ready is combinational)
//   in_op, in_a, in_b       operation select and operands
//   in_flush                synchronous clear of both pipeline valids
//   out_valid/out_ready     output handshake
//   out_result/out_zero/out_parity  registered result and flags
// Optional: define LOGIC_UNIT_CNT_EN to add out_count, a 16-bit wrapping
//   count of completed output transfers (unaffected by in_flush).
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_parity
`ifdef LOGIC_UNIT_CNT_EN
  ,
  output logic [15:0]      out_count
`endif
);

  localparam int unsigned OP_W  = 3;
  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s1_payload_t;

  // Pipeline state
  logic             s1_valid_q, s1_valid_d;
  s1_payload_t      s1_data_q, s1_data_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;

  logic             out_xfer_c;
  logic             s2_load_c;
  logic             s1_adv_c;
  logic             in_xfer_c;
  logic [WIDTH-1:0] s2_result_c;

  // Handshake and advance decisions
  always_comb begin
    out_xfer_c = s2_valid_q && out_ready;
    s2_load_c  = !s2_valid_q || out_xfer_c;
    s1_adv_c   = s1_valid_q && s2_load_c;
    in_ready   = (!s1_valid_q || s2_load_c) && !in_flush;
    in_xfer_c  = in_valid && in_ready;
  end

  // Bitwise operation on the S1 contents
  always_comb begin
    s2_result_c = '0;
    unique case (s1_data_q.op)
      3'b000:  s2_result_c = s1_data_q.a & s1_data_q.b;
      3'b001:  s2_result_c = s1_data_q.a | s1_data_q.b;
      3'b010:  s2_result_c = s1_data_q.a ^ s1_data_q.b;
      3'b011:  s2_result_c = ~(s1_data_q.a ^ s1_data_q.b);
      3'b100:  s2_result_c = ~(s1_data_q.a & s1_data_q.b);
      3'b101:  s2_result_c = ~(s1_data_q.a | s1_data_q.b);
      3'b110:  s2_result_c = ~s1_data_q.a;
      default: s2_result_c = s1_data_q.a;
    endcase
  end

  // Next-state for both stages; flush only drops valids, data may stay stale
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    zero_d     = zero_q;
    parity_d   = parity_q;

    if (in_xfer_c) begin
      s1_data_d = '{op: in_op, a: in_a, b: in_b};
    end
    if (!s1_valid_q || s2_load_c) begin
      s1_valid_d = in_xfer_c;
    end

    if (s1_adv_c) begin
      result_d = s2_result_c;
      zero_d   = (s2_result_c == '0);
      parity_d = ^s2_result_c;
    end
    if (s2_load_c) begin
      s2_valid_d = s1_valid_q;
    end

    if (in_flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      parity_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      parity_q   <= parity_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = result_q;
  assign out_zero   = zero_q;
  assign out_parity = parity_q;

`ifdef LOGIC_UNIT_CNT_EN
  // Completed-transfer counter; wraps naturally at 16 bits
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + CNT_W'(out_xfer_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_count = count_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed self-checking bench for logic_unit_pipe
// (WIDTH=8 main instance, WIDTH=1 secondary instance; counter checks when
// LOGIC_UNIT_CNT_EN is defined).
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, in_flush;
  logic [2:0] in_op;
  logic [7:0] in_a, in_b;
  logic       out_valid, out_ready;
  logic [7:0] out_result;
  logic       out_zero, out_parity;

  logic       w1_in_valid, w1_in_ready;
  logic [2:0] w1_in_op;
  logic [0:0] w1_in_a, w1_in_b;
  logic       w1_out_valid;
  logic [0:0] w1_out_result;
  logic       w1_out_zero, w1_out_parity;

`ifdef LOGIC_UNIT_CNT_EN
  logic [15:0] out_count;
  logic [15:0] w1_out_count;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_ops [8];

  logic_unit_pipe #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_flush   (in_flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_parity (out_parity)
`ifdef LOGIC_UNIT_CNT_EN
    ,
    .out_count  (out_count)
`endif
  );

  logic_unit_pipe #(.WIDTH(1)) dut_w1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (w1_in_valid),
    .in_ready   (w1_in_ready),
    .in_op      (w1_in_op),
    .in_a       (w1_in_a),
    .in_b       (w1_in_b),
    .in_flush   (1'b0),
    .out_valid  (w1_out_valid),
    .out_ready  (1'b1),
    .out_result (w1_out_result),
    .out_zero   (w1_out_zero),
    .out_parity (w1_out_parity)
`ifdef LOGIC_UNIT_CNT_EN
    ,
    .out_count  (w1_out_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  initial begin
    exp_ops = '{8'hC0, 8'hFC, 8'h3C, 8'hC3, 8'h3F, 8'h03, 8'h0F, 8'hF0};
    rst_n = 1'b0;
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    in_flush = 1'b0;
    out_ready = 1'b1;
    w1_in_valid = 1'b0;
    w1_in_op = 3'b000;
    w1_in_a = 1'b0;
    w1_in_b = 1'b0;
    #1;
    // Reset values
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_out_result", 64'(out_result), 64'(0));
    check_eq("rst_out_zero", 64'(out_zero), 64'(0));
    check_eq("rst_out_parity", 64'(out_parity), 64'(0));
`ifdef LOGIC_UNIT_CNT_EN
    check_eq("rst_count", 64'(out_count), 64'(0));
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic XOR with 2-cycle latency
    drive(1'b1, 3'b010, 8'hA5, 8'h0F);
    #1;
    check_eq("basic_in_ready", 64'(in_ready), 64'(1));
    tick();
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    check_eq("basic_lat1_valid", 64'(out_valid), 64'(0));
    tick();
    check_eq("basic_valid", 64'(out_valid), 64'(1));
    check_eq("basic_result", 64'(out_result), 64'(8'hAA));
    check_eq("basic_zero", 64'(out_zero), 64'(0));
    check_eq("basic_parity", 64'(out_parity), 64'(0));
    tick();
    check_eq("basic_drained", 64'(out_valid), 64'(0));

    // All eight ops streamed back-to-back
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, 3'(i), 8'hF0, 8'hCC);
      else drive(1'b0, 3'b000, 8'hF0, 8'hCC);
      tick();
      if (i >= 1 && i <= 8) begin
        check_eq($sformatf("ops_valid_%0d", i - 1), 64'(out_valid), 64'(1));
        check_eq($sformatf("ops_result_%0d", i - 1), 64'(out_result), 64'(exp_ops[i-1]));
        check_eq($sformatf("ops_zero_%0d", i - 1), 64'(out_zero), 64'(exp_ops[i-1] == 8'h00));
        check_eq($sformatf("ops_parity_%0d", i - 1), 64'(out_parity), 64'(^exp_ops[i-1]));
      end
    end
    tick();
    check_eq("ops_drained", 64'(out_valid), 64'(0));

    // Zero flag
    drive(1'b1, 3'b010, 8'h5A, 8'h5A);
    tick();
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    tick();
    check_eq("zero_valid", 64'(out_valid), 64'(1));
    check_eq("zero_result", 64'(out_result), 64'(0));
    check_eq("zero_zero", 64'(out_zero), 64'(1));
    check_eq("zero_parity", 64'(out_parity), 64'(0));
    tick();

    // Backpressure: third transaction blocked until out_ready returns
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 8'hFF, 8'h0F);      // -> 0F
    #1;
    check_eq("bp_ready0", 64'(in_ready), 64'(1));
    tick();
    drive(1'b1, 3'b001, 8'h10, 8'h01);      // -> 11
    #1;
    check_eq("bp_ready1", 64'(in_ready), 64'(1));
    tick();
    drive(1'b1, 3'b010, 8'h33, 8'h0F);      // -> 3C
    #1;
    check_eq("bp_ready2_blocked", 64'(in_ready), 64'(0));
    check_eq("bp_head_result", 64'(out_result), 64'(8'h0F));
    tick();
    check_eq("bp_stall_valid", 64'(out_valid), 64'(1));
    check_eq("bp_stall_result", 64'(out_result), 64'(8'h0F));
    check_eq("bp_stall_ready", 64'(in_ready), 64'(0));
    tick();
    check_eq("bp_stall2_result", 64'(out_result), 64'(8'h0F));
    out_ready = 1'b1;
    #1;
    check_eq("bp_ready_resume", 64'(in_ready), 64'(1));
    tick();
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    check_eq("bp_out1_valid", 64'(out_valid), 64'(1));
    check_eq("bp_out1_result", 64'(out_result), 64'(8'h11));
    tick();
    check_eq("bp_out2_valid", 64'(out_valid), 64'(1));
    check_eq("bp_out2_result", 64'(out_result), 64'(8'h3C));
    tick();
    check_eq("bp_drained", 64'(out_valid), 64'(0));

    // Flush with two entries in flight and a simultaneous offer
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 8'hAA, 8'hFF);
    tick();
    drive(1'b1, 3'b011, 8'h00, 8'h00);
    tick();
    check_eq("fl_full_valid", 64'(out_valid), 64'(1));
    drive(1'b1, 3'b111, 8'h77, 8'h00);
    in_flush = 1'b1;
    #1;
    check_eq("fl_in_ready", 64'(in_ready), 64'(0));
    tick();
    in_flush = 1'b0;
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    check_eq("fl_out_valid", 64'(out_valid), 64'(0));
    tick();
    check_eq("fl_not_accepted", 64'(out_valid), 64'(0));
    out_ready = 1'b1;
    drive(1'b1, 3'b101, 8'h0F, 8'hF0);      // NOR -> 00
    tick();
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    check_eq("fl_new_lat1", 64'(out_valid), 64'(0));
    tick();
    check_eq("fl_new_valid", 64'(out_valid), 64'(1));
    check_eq("fl_new_result", 64'(out_result), 64'(0));
    check_eq("fl_new_zero", 64'(out_zero), 64'(1));
    tick();

    // WIDTH=1 XNOR
    w1_in_valid = 1'b1;
    w1_in_op = 3'b011;
    w1_in_a = 1'b1;
    w1_in_b = 1'b1;
    tick();
    w1_in_valid = 1'b0;
    tick();
    check_eq("w1_valid", 64'(w1_out_valid), 64'(1));
    check_eq("w1_result", 64'(w1_out_result), 64'(1));
    check_eq("w1_parity", 64'(w1_out_parity), 64'(1));
    check_eq("w1_zero", 64'(w1_out_zero), 64'(0));
    tick();

`ifdef LOGIC_UNIT_CNT_EN
    // 14 transfers so far; stream to the wrap point
    check_eq("cnt_so_far", 64'(out_count), 64'(14));
    drive(1'b1, 3'b111, 8'h01, 8'h00);
    for (int i = 0; i < 65522; i++) tick();
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    tick();
    tick();
    check_eq("cnt_wrap", 64'(out_count), 64'(0));
    drive(1'b1, 3'b111, 8'h01, 8'h00);
    tick();
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    tick();
    tick();
    check_eq("cnt_after_wrap", 64'(out_count), 64'(1));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
